// File: rtl/game_timer_pkg.sv
// game_timer_pkg: shared FSM state type and count-direction constants for game_timer.
package game_timer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_e;
  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;
endpackage

// File: rtl/game_timer.sv
// game_timer: start/stop/load up-down timer that wraps or saturates at terminal count.
// Defining GAME_TIMER_LAP_EN adds lap_i/lap_o to capture count_o into a lap register.
module game_timer
  import game_timer_pkg::*;
#(
  parameter int               WIDTH     = 5,
  parameter logic [WIDTH-1:0] RESET_VAL = '1,
  parameter bit               WRAP      = 1'b1
) (
  input  logic             clk_4_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] count_o,
  output logic             running_o,
  output logic             tc_o,
`ifdef GAME_TIMER_LAP_EN
  input  logic             lap_i,
  output logic [WIDTH-1:0] lap_o,
`endif
  output logic             done_o
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d, term;
  logic             running_q, done_q, at_term;
  always_comb begin
    term    = (dir_i == DIR_UP) ? '1 : '0;
    at_term = count_q == term;
    state_d = state_q;
    count_d = count_q;
    if (load_i) begin
      state_d = IDLE;
      count_d = load_val_i;
    end else if (state_q == RUN) begin
      if (stop_i) state_d = HOLD;
      else if (!WRAP && at_term) state_d = DONE;
      else count_d = (dir_i == DIR_UP) ? count_q + 1'b1 : count_q - 1'b1;
    end else if (start_i && !stop_i && state_q != DONE) begin
      state_d = RUN;
    end
  end
  // running/done are registered from the next state so they track state_q exactly
  always_ff @(posedge clk_4_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      count_q   <= RESET_VAL;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      running_q <= state_d == RUN;
      done_q    <= state_d == DONE;
    end
  end
  assign count_o   = count_q;
  assign running_o = running_q;
  assign done_o    = done_q;
  assign tc_o      = running_q && at_term;
`ifdef GAME_TIMER_LAP_EN
  logic [WIDTH-1:0] lap_q, lap_d;
  always_comb lap_d = lap_i ? count_q : lap_q;
  always_ff @(posedge clk_4_i or negedge rst_ni) begin
    if (!rst_ni) lap_q <= '0;
    else lap_q <= lap_d;
  end
  assign lap_o = lap_q;
`endif
endmodule

// File: tb/tb_game_timer.sv
// tb_game_timer: random and directed checks of a wrapping and a saturating game_timer
// against a behavioural model; lap capture is exercised when GAME_TIMER_LAP_EN is defined.
module tb_game_timer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, load = 1'b0, dir = 1'b0, lap = 1'b0;
  logic [4:0] load_val = '0;
  logic [4:0] cnt_o [2];
  logic [4:0] lap_o [2];
  logic       run_o [2], tc_o [2], done_o [2];
  int         checks = 0, errors = 0;
  int         m_cnt [2], m_lap [2];
  bit         m_run [2], m_done [2];
  bit         m_wrap [2] = '{1'b1, 1'b0};

  always #5 clk = ~clk;

  game_timer #(.WIDTH(5), .WRAP(1'b1)) u_wrap (
    .clk_4_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop), .load_i(load),
    .load_val_i(load_val), .dir_i(dir), .count_o(cnt_o[0]), .running_o(run_o[0]),
    .tc_o(tc_o[0]),
`ifdef GAME_TIMER_LAP_EN
    .lap_i(lap), .lap_o(lap_o[0]),
`endif
    .done_o(done_o[0]));

  game_timer #(.WIDTH(5), .WRAP(1'b0)) u_sat (
    .clk_4_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop), .load_i(load),
    .load_val_i(load_val), .dir_i(dir), .count_o(cnt_o[1]), .running_o(run_o[1]),
    .tc_o(tc_o[1]),
`ifdef GAME_TIMER_LAP_EN
    .lap_i(lap), .lap_o(lap_o[1]),
`endif
    .done_o(done_o[1]));

`ifndef GAME_TIMER_LAP_EN
  assign lap_o[0] = '0;
  assign lap_o[1] = '0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 31; m_run[i] = 0; m_done[i] = 0; m_lap[i] = 0;
    end
  endtask

  // one rising edge of the timer, from the rules: load > stop > start, modulo-32 counting
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int term;
      term = dir ? 31 : 0;
      if (lap) m_lap[i] = m_cnt[i];
      if (load) begin
        m_cnt[i] = load_val; m_run[i] = 0; m_done[i] = 0;
      end else if (m_run[i]) begin
        if (stop) m_run[i] = 0;
        else if (!m_wrap[i] && m_cnt[i] == term) begin
          m_run[i] = 0; m_done[i] = 1;
        end else m_cnt[i] = (m_cnt[i] + (dir ? 1 : 31)) % 32;
      end else if (start && !stop && !m_done[i]) m_run[i] = 1;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      string n;
      n = i == 0 ? "wrap" : "sat";
      check({n, ".count"}, cnt_o[i], m_cnt[i]);
      check({n, ".running"}, run_o[i], m_run[i]);
      check({n, ".tc"}, tc_o[i], m_run[i] && m_cnt[i] == (dir ? 31 : 0));
      check({n, ".done"}, done_o[i], m_done[i]);
`ifdef GAME_TIMER_LAP_EN
      check({n, ".lap"}, lap_o[i], m_lap[i]);
`endif
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input logic l, input logic sp, input logic st, input logic [4:0] v);
    load = l; stop = sp; start = st; load_val = v;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    check_all();
    check("reset.count", cnt_o[0], 31);
    rst_n = 1'b1;
    // wrap / saturate from 2 counting down
    drive(1, 0, 0, 2); cyc();
    drive(0, 0, 1, 0); cyc();
    check("wrap.first", cnt_o[0], 2);
    drive(0, 0, 0, 0); cyc(); cyc();
    check("wrap.tc_at0", tc_o[0], 1);
    cyc();
    check("wrap.to31", cnt_o[0], 31);
    check("sat.done", done_o[1], 1);
    check("sat.held", cnt_o[1], 0);
    cyc();
    check("wrap.to30", cnt_o[0], 30);
    check("wrap.tc_off", tc_o[0], 0);
    drive(0, 0, 1, 0); cyc();
    check("sat.start_ignored", done_o[1], 1);
    // all controls together while running
    drive(1, 1, 1, 7); cyc();
    check("prio.count", cnt_o[0], 7);
    check("prio.idle", run_o[0], 0);
    // pause and reverse
    drive(1, 0, 0, 10); cyc();
    drive(0, 0, 1, 0); cyc();
    drive(0, 0, 0, 0); cyc(); cyc(); cyc();
    drive(0, 1, 0, 0); cyc(); drive(0, 0, 0, 0); cyc();
    check("pause.hold", cnt_o[0], 7);
    dir = 1'b1;
    drive(0, 0, 1, 0); cyc();
    drive(0, 0, 0, 0); cyc(); cyc();
    check("up.count", cnt_o[0], 9);
`ifdef GAME_TIMER_LAP_EN
    drive(1, 0, 0, 10); cyc();
    drive(0, 0, 1, 0); cyc();
    drive(0, 0, 0, 0); cyc(); cyc();
    lap = 1'b1; cyc(); lap = 1'b0;
    check("lap.value", lap_o[0], 12);
    check("lap.counting", cnt_o[0], 13);
`endif
    // asynchronous reset mid-run, checked before the next edge
    #2 rst_n = 1'b0;
    #1;
    check("areset.count", cnt_o[0], 31);
    check("areset.running", run_o[0], 0);
    check("areset.tc", tc_o[0], 0);
    model_reset();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    for (int k = 0; k < 400; k++) begin
      load     = $urandom_range(0, 15) == 0;
      stop     = $urandom_range(0, 7) == 0;
      start    = $urandom_range(0, 3) == 0;
      dir      = $urandom_range(0, 5) == 0 ? ~dir : dir;
      lap      = $urandom_range(0, 7) == 0;
      load_val = 5'($urandom);
      cyc();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
